bus_protect_mc: RTL and testbench
=================================

Name: bus_protect_mc

Overview:
Multi-channel successor to the single-bus overvoltage protector; monitors N_CH DC-bus voltages from one sequenced ADC stream plus per-channel hardware comparators.
Per channel: warn/alarm levels with hysteresis, deglitched ADC trip, latched trip, keyed clear, telemetry.
Any tripped channel drives the shared active-low EPO.
Sits between the ADC sequencer and the power-stage EPO net in the safety subsystem.

Parameters:
N_CH, 4, number of monitored buses (1..16)
ADC_BITS, 12, ADC sample width
WARN_THR, 2839, warn level (52 V at 18.31 mV/LSB)
ALARM_THR, 3003, alarm level (55 V)
TRIP_THR, 3167, trip level (58 V)
HYST, 55, hysteresis in LSB (~1 V) for warn/alarm release and clear eligibility
DEGLITCH_CYCLES, 50000, consecutive clocks over TRIP_THR before trip (1 ms at 50 MHz); must be >= 1
CLEAR_KEY, 16'hA5C3, key required with clear_trip
CNT_BITS, 16, per-channel trip counter width (saturating)

Ports:
clk  in  1  system clock, 50 MHz
rst  in  1  synchronous, active-high reset
adc_data  in  ADC_BITS  sample
adc_ch  in  $clog2(N_CH) (min 1)  channel of sample; values >= N_CH ignored
adc_valid  in  1  sample strobe, any rate up to one per clock
hw_ov  in  N_CH  hardware comparator per channel, pre-deglitched
enable  in  1  protection enable; 0 blocks new trips only
clear_trip  in  1  clear request, single-cycle pulse
clear_key  in  16  key sampled with clear_trip
epo_out_n  out  1  emergency power off, active low
warning  out  N_CH  per-channel warn
alarm  out  N_CH  per-channel alarm
tripped  out  N_CH  per-channel latched trip
trip_src_hw  out  N_CH  1 = last trip came from hw_ov, 0 = ADC
key_error  out  1  one-cycle pulse on clear_trip with wrong key
tel_sel  in  $clog2(N_CH)  telemetry channel select
tel_last  out  ADC_BITS  last sample of tel_sel
tel_peak  out  ADC_BITS  peak sample of tel_sel
tel_trip_count  out  CNT_BITS  trip count of tel_sel

Behaviour:
- Reset clears all outputs and internal state to 0, except epo_out_n = 1. All channels enter NORMAL. Reset overrides a trip in progress.
- Per-channel FSM states:
  - NORMAL -> WARN: sample >= WARN_THR.
  - WARN -> ALARM: sample >= ALARM_THR.
  - WARN -> NORMAL: sample < WARN_THR-HYST.
  - ALARM -> WARN: sample < ALARM_THR-HYST.
  - Any non-TRIPPED state -> PEND: sample >= TRIP_THR.
  - PEND -> ALARM: sample < TRIP_THR.
  - PEND -> TRIPPED: deglitch count reaches DEGLITCH_CYCLES and enable = 1.
  - TRIPPED -> NORMAL: valid clear only.
  - Within the hysteresis band the state holds. Samples jumping several levels go straight to the highest qualifying state.
- Outputs by state:
  - warning = 1 in WARN, ALARM, PEND.
  - alarm = 1 in ALARM, PEND.
  - Both are also held at 1 in TRIPPED.
  - All registered: one cycle after the adc_valid sample.
- Deglitch:
  - Per-channel counter, increments every clk while in PEND, independent of sample rate.
  - Trip on the cycle the count equals DEGLITCH_CYCLES-1 with enable = 1.
  - Counter zeroes on leaving PEND.
  - With enable = 0 it saturates at DEGLITCH_CYCLES-1, and the trip fires when enable rises while still in PEND.
- HW fast path: hw_ov[i] with enable = 1 sends channel i to TRIPPED. tripped[i] and epo_out_n = 0 appear one clk later, with trip_src_hw[i] = 1.
- Same-cycle ADC and HW trip on a channel: trip_src_hw = 1, counter increments once.
- trip_count increments once per NORMAL/WARN/ALARM/PEND -> TRIPPED transition and saturates at all-ones.
- epo_out_n = NOR of next-state tripped, registered.
- Clear:
  - clear_trip with clear_key == CLEAR_KEY returns every TRIPPED channel whose last sample < TRIP_THR-HYST and whose hw_ov = 0 to NORMAL.
  - Ineligible channels stay TRIPPED.
  - A clear does not depend on enable.
  - A wrong key changes no state and produces the key_error pulse.
  - If clear_trip coincides with a hw_ov or trip-level sample on a channel, the trip wins.
- Telemetry:
  - last/peak are updated on adc_valid; peak = max.
  - Peak is never cleared except by rst.
  - tel_* outputs are registered mux outputs, one clk latency from tel_sel.
  - Out-of-range tel_sel reads 0.

Decomposition:
- Package bus_protect_pkg holds the FSM state enum (3-bit encoding) and the CLEAR_KEY default.
- One sub-module, bus_protect_ch: per-channel FSM, deglitch counter, last/peak/count registers.
- The top level instantiates N_CH copies and adds channel decode, EPO reduction, clear/key logic and the telemetry mux.

Test Plan:
- Ch2 sample sequence 2839, then 2800, then 2783: warning[2]=1 after the first sample, still 1 after 2800 (within hysteresis), 0 after 2783 (< 2784).
- Ch1 held at 3167 with DEGLITCH_CYCLES=10: tripped[1]=1 and epo_out_n=0 exactly 10 clks after entering PEND; a dip to 3166 at clk 5 aborts, with alarm=1 and count reset.
- hw_ov[3] pulse for 1 clk: tripped[3]=1, trip_src_hw[3]=1, epo_out_n=0 the next clk and held after hw_ov drops; tel_trip_count(ch3)=1.
- Clear with key 16'h0000: key_error pulse, trip held. Clear with 16'hA5C3 while last=3150: trip held. After sample 3000, clear: tripped=0, epo_out_n=1.
- enable=0 with ch0 at 3200 for 2×DEGLITCH_CYCLES: no trip. enable then 1: trip next clk.
- Reset asserted mid-PEND and while TRIPPED: all outputs 0, epo_out_n=1, peak=0 the next clk.

Source files
------------

// File: rtl/bus_protect_pkg.sv
// rtl/bus_protect_pkg.sv - shared types and defaults for the multi-channel bus protector
package bus_protect_pkg;

   typedef enum logic [2:0] {
      ST_NORMAL  = 3'd0,
      ST_WARN    = 3'd1,
      ST_ALARM   = 3'd2,
      ST_PEND    = 3'd3,
      ST_TRIPPED = 3'd4
   } ch_state_t;

   localparam logic [15:0] CLEAR_KEY_DEFAULT = 16'hA5C3;

endpackage

// File: rtl/bus_protect_ch.sv
// rtl/bus_protect_ch.sv - one monitored bus: level FSM, deglitch, latched trip, telemetry registers
module bus_protect_ch
   import bus_protect_pkg::*;
#(
   parameter int ADC_BITS        = 12,
   parameter int WARN_THR        = 2839,
   parameter int ALARM_THR       = 3003,
   parameter int TRIP_THR        = 3167,
   parameter int HYST            = 55,
   parameter int DEGLITCH_CYCLES = 50000,
   parameter int CNT_BITS        = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ADC_BITS-1:0] sample,
   input  logic                sample_valid,
   input  logic                hw_ov,
   input  logic                enable,
   input  logic                clear,
   output logic                warning,
   output logic                alarm,
   output logic                tripped,
   output logic                trip_src_hw,
   output logic                trip_next,
   output logic [ADC_BITS-1:0] last,
   output logic [ADC_BITS-1:0] peak,
   output logic [CNT_BITS-1:0] trip_count
);

   localparam int DEG_W = (DEGLITCH_CYCLES > 1) ? $clog2(DEGLITCH_CYCLES) : 1;
   localparam logic [DEG_W-1:0]    DEG_MAX   = DEG_W'(DEGLITCH_CYCLES - 1);
   localparam logic [ADC_BITS-1:0] WARN_L    = ADC_BITS'(WARN_THR);
   localparam logic [ADC_BITS-1:0] ALARM_L   = ADC_BITS'(ALARM_THR);
   localparam logic [ADC_BITS-1:0] TRIP_L    = ADC_BITS'(TRIP_THR);
   localparam logic [ADC_BITS-1:0] WARN_REL  = ADC_BITS'(WARN_THR - HYST);
   localparam logic [ADC_BITS-1:0] ALARM_REL = ADC_BITS'(ALARM_THR - HYST);
   localparam logic [ADC_BITS-1:0] TRIP_REL  = ADC_BITS'(TRIP_THR - HYST);

   ch_state_t           state, state_n;
   logic [DEG_W-1:0]    cnt, cnt_n;
   logic                src_n;
   logic [ADC_BITS-1:0] cur_sample;

   // Sample-driven transitions for the non-latched states; large drops fall straight to NORMAL.
   function automatic ch_state_t level_next(input ch_state_t s, input logic [ADC_BITS-1:0] x);
      if (x >= TRIP_L) return ST_PEND;
      case (s)
         ST_NORMAL: return (x >= ALARM_L) ? ST_ALARM : ((x >= WARN_L) ? ST_WARN : ST_NORMAL);
         ST_WARN:   return (x >= ALARM_L) ? ST_ALARM : ((x < WARN_REL) ? ST_NORMAL : ST_WARN);
         ST_ALARM:  return (x < WARN_REL) ? ST_NORMAL : ((x < ALARM_REL) ? ST_WARN : ST_ALARM);
         ST_PEND:   return ST_ALARM;
         default:   return s;
      endcase
   endfunction

   always_comb begin
      state_n    = state;
      cnt_n      = '0;
      src_n      = trip_src_hw;
      cur_sample = sample_valid ? sample : last;
      if (state == ST_TRIPPED) begin
         // A trip-level sample this cycle makes cur_sample ineligible, so the trip wins.
         if (clear && !hw_ov && (cur_sample < TRIP_REL))
            state_n = ST_NORMAL;
      end else if (hw_ov && enable) begin
         state_n = ST_TRIPPED;
         src_n   = 1'b1;
      end else begin
         if (sample_valid)
            state_n = level_next(state, sample);
         if ((state == ST_PEND) && (state_n == ST_PEND)) begin
            if (cnt == DEG_MAX) begin
               if (enable) begin
                  state_n = ST_TRIPPED;
                  src_n   = 1'b0;
               end else begin
                  cnt_n = cnt;
               end
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
      end
   end

   assign trip_next = (state_n == ST_TRIPPED);

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= ST_NORMAL;
         cnt         <= '0;
         warning     <= 1'b0;
         alarm       <= 1'b0;
         tripped     <= 1'b0;
         trip_src_hw <= 1'b0;
         last        <= '0;
         peak        <= '0;
         trip_count  <= '0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         trip_src_hw <= src_n;
         warning     <= state_n inside {ST_WARN, ST_ALARM, ST_PEND, ST_TRIPPED};
         alarm       <= state_n inside {ST_ALARM, ST_PEND, ST_TRIPPED};
         tripped     <= (state_n == ST_TRIPPED);
         if (sample_valid) begin
            last <= sample;
            if (sample > peak)
               peak <= sample;
         end
         if ((state != ST_TRIPPED) && (state_n == ST_TRIPPED) && (trip_count != '1))
            trip_count <= trip_count + 1'b1;
      end
   end

endmodule

// File: rtl/bus_protect_mc.sv
// rtl/bus_protect_mc.sv - N-channel DC-bus overvoltage protector driving the shared EPO
module bus_protect_mc
   import bus_protect_pkg::*;
#(
   parameter int          N_CH            = 4,
   parameter int          ADC_BITS        = 12,
   parameter int          WARN_THR        = 2839,
   parameter int          ALARM_THR       = 3003,
   parameter int          TRIP_THR        = 3167,
   parameter int          HYST            = 55,
   parameter int          DEGLITCH_CYCLES = 50000,
   parameter logic [15:0] CLEAR_KEY       = CLEAR_KEY_DEFAULT,
   parameter int          CNT_BITS        = 16,
   localparam int         CH_W            = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic                clk,
   input  logic                rst,
   input  logic [ADC_BITS-1:0] adc_data,
   input  logic [CH_W-1:0]     adc_ch,
   input  logic                adc_valid,
   input  logic [N_CH-1:0]     hw_ov,
   input  logic                enable,
   input  logic                clear_trip,
   input  logic [15:0]         clear_key,
   output logic                epo_out_n,
   output logic [N_CH-1:0]     warning,
   output logic [N_CH-1:0]     alarm,
   output logic [N_CH-1:0]     tripped,
   output logic [N_CH-1:0]     trip_src_hw,
   output logic                key_error,
   input  logic [CH_W-1:0]     tel_sel,
   output logic [ADC_BITS-1:0] tel_last,
   output logic [ADC_BITS-1:0] tel_peak,
   output logic [CNT_BITS-1:0] tel_trip_count
);

   logic                clear_ok;
   logic [N_CH-1:0]     trip_next;
   logic [ADC_BITS-1:0] last_a  [N_CH];
   logic [ADC_BITS-1:0] peak_a  [N_CH];
   logic [CNT_BITS-1:0] count_a [N_CH];

   assign clear_ok = clear_trip && (clear_key == CLEAR_KEY);

   for (genvar i = 0; i < N_CH; i++) begin : g_ch
      bus_protect_ch #(
         .ADC_BITS        (ADC_BITS),
         .WARN_THR        (WARN_THR),
         .ALARM_THR       (ALARM_THR),
         .TRIP_THR        (TRIP_THR),
         .HYST            (HYST),
         .DEGLITCH_CYCLES (DEGLITCH_CYCLES),
         .CNT_BITS        (CNT_BITS)
      ) u_ch (
         .clk          (clk),
         .rst          (rst),
         .sample       (adc_data),
         .sample_valid (adc_valid && (adc_ch == CH_W'(i))),
         .hw_ov        (hw_ov[i]),
         .enable       (enable),
         .clear        (clear_ok),
         .warning      (warning[i]),
         .alarm        (alarm[i]),
         .tripped      (tripped[i]),
         .trip_src_hw  (trip_src_hw[i]),
         .trip_next    (trip_next[i]),
         .last         (last_a[i]),
         .peak         (peak_a[i]),
         .trip_count   (count_a[i])
      );
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         epo_out_n      <= 1'b1;
         key_error      <= 1'b0;
         tel_last       <= '0;
         tel_peak       <= '0;
         tel_trip_count <= '0;
      end else begin
         epo_out_n <= ~|trip_next;
         key_error <= clear_trip && (clear_key != CLEAR_KEY);
         if (int'(tel_sel) < N_CH) begin
            tel_last       <= last_a[tel_sel];
            tel_peak       <= peak_a[tel_sel];
            tel_trip_count <= count_a[tel_sel];
         end else begin
            tel_last       <= '0;
            tel_peak       <= '0;
            tel_trip_count <= '0;
         end
      end
   end

endmodule

// File: tb/tb_bus_protect_mc.sv
// tb/tb_bus_protect_mc.sv - directed self-checking bench for bus_protect_mc
module tb_bus_protect_mc;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [11:0] adc_data = '0;
   logic [1:0]  adc_ch = '0;
   logic        adc_valid = 1'b0;
   logic [3:0]  hw_ov = '0;
   logic        enable = 1'b0;
   logic        clear_trip = 1'b0;
   logic [15:0] clear_key = '0;
   logic        epo_out_n;
   logic [3:0]  warning, alarm, tripped, trip_src_hw;
   logic        key_error;
   logic [1:0]  tel_sel = '0;
   logic [11:0] tel_last, tel_peak;
   logic [15:0] tel_trip_count;

   int n_checks = 0;
   int n_fail   = 0;

   bus_protect_mc #(.N_CH(4), .DEGLITCH_CYCLES(10)) dut (
      .clk            (clk),
      .rst            (rst),
      .adc_data       (adc_data),
      .adc_ch         (adc_ch),
      .adc_valid      (adc_valid),
      .hw_ov          (hw_ov),
      .enable         (enable),
      .clear_trip     (clear_trip),
      .clear_key      (clear_key),
      .epo_out_n      (epo_out_n),
      .warning        (warning),
      .alarm          (alarm),
      .tripped        (tripped),
      .trip_src_hw    (trip_src_hw),
      .key_error      (key_error),
      .tel_sel        (tel_sel),
      .tel_last       (tel_last),
      .tel_peak       (tel_peak),
      .tel_trip_count (tel_trip_count)
   );

   always #10 clk = ~clk;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick(input int n = 1);
      for (int k = 0; k < n; k++) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic send(input int ch, input int val);
      adc_ch    = 2'(ch);
      adc_data  = 12'(val);
      adc_valid = 1'b1;
      tick();
      adc_valid = 1'b0;
   endtask

   task automatic do_clear(input logic [15:0] key);
      clear_trip = 1'b1;
      clear_key  = key;
      tick();
      clear_trip = 1'b0;
   endtask

   initial begin
      tick(2);
      rst = 1'b0;
      check_eq("rst_epo", epo_out_n, 1);
      check_eq("rst_warn", warning, 0);
      check_eq("rst_alarm", alarm, 0);
      check_eq("rst_trip", tripped, 0);
      check_eq("rst_keyerr", key_error, 0);
      enable = 1'b1;

      // warn hysteresis on ch2
      send(2, 2839);  check_eq("w_set", warning, 4'b0100);
      check_eq("w_noalarm", alarm, 0);
      send(2, 2800);  check_eq("w_hold", warning, 4'b0100);
      send(2, 2783);  check_eq("w_rel", warning, 0);
      send(2, 3003);  check_eq("a_set", alarm, 4'b0100);
      send(2, 2948);  check_eq("a_hold", alarm, 4'b0100);
      send(2, 2947);  check_eq("a_rel", alarm, 0);
      check_eq("a_rel_warn", warning, 4'b0100);
      send(2, 2000);  check_eq("jump_normal", warning, 0);

      // deglitch abort then full trip on ch1
      send(1, 3167);  check_eq("pend_alarm", alarm, 4'b0010);
      tick(4);
      send(1, 3166);  check_eq("dip_alarm", alarm, 4'b0010);
      check_eq("dip_notrip", tripped, 0);
      send(1, 3167);
      tick(9);        check_eq("deg_early", tripped, 0);
      check_eq("deg_early_epo", epo_out_n, 1);
      tick();         check_eq("deg_trip", tripped, 4'b0010);
      check_eq("deg_epo", epo_out_n, 0);
      check_eq("deg_src", trip_src_hw, 0);
      tel_sel = 2'd1;
      tick();         check_eq("tel1_cnt", tel_trip_count, 1);
      check_eq("tel1_last", tel_last, 3167);
      check_eq("tel1_peak", tel_peak, 3167);

      // hardware fast path on ch3
      hw_ov = 4'b1000;
      tick();
      hw_ov = 4'b0000;
      check_eq("hw_trip", tripped, 4'b1010);
      check_eq("hw_src", trip_src_hw, 4'b1000);
      tel_sel = 2'd3;
      tick();         check_eq("hw_hold", tripped, 4'b1010);
      check_eq("tel3_cnt", tel_trip_count, 1);

      // keyed clear
      do_clear(16'h0000);
      check_eq("badkey_pulse", key_error, 1);
      check_eq("badkey_hold", tripped, 4'b1010);
      tick();         check_eq("badkey_end", key_error, 0);
      send(1, 3150);
      do_clear(16'hA5C3);
      check_eq("clr_partial", tripped, 4'b0010);
      check_eq("clr_nokeyerr", key_error, 0);
      check_eq("clr_epo_low", epo_out_n, 0);
      send(1, 3000);
      do_clear(16'hA5C3);
      check_eq("clr_all", tripped, 0);
      check_eq("clr_epo", epo_out_n, 1);
      check_eq("clr_normal", alarm, 0);

      // hw_ov held during clear keeps the trip
      hw_ov = 4'b1000;
      tick();
      do_clear(16'hA5C3);
      check_eq("clr_vs_hw", tripped, 4'b1000);
      hw_ov = 4'b0000;
      do_clear(16'hA5C3);
      check_eq("clr_after_hw", tripped, 0);
      tick();         check_eq("tel3_cnt2", tel_trip_count, 2);

      // enable gating on ch0
      enable = 1'b0;
      send(0, 3200);
      tick(20);       check_eq("en0_notrip", tripped, 0);
      check_eq("en0_alarm", alarm, 4'b0001);
      enable = 1'b1;
      tick();         check_eq("en1_trip", tripped, 4'b0001);
      check_eq("en1_epo", epo_out_n, 0);

      // reset while tripped (ch0) and mid-pend (ch1)
      send(1, 3200);
      tick(3);
      tel_sel = 2'd0;
      rst = 1'b1;
      tick();
      check_eq("rst2_trip", tripped, 0);
      check_eq("rst2_alarm", alarm, 0);
      check_eq("rst2_warn", warning, 0);
      check_eq("rst2_epo", epo_out_n, 1);
      check_eq("rst2_src", trip_src_hw, 0);
      rst = 1'b0;
      tick();
      check_eq("rst2_peak", tel_peak, 0);
      check_eq("rst2_cnt", tel_trip_count, 0);
      tick(12);       check_eq("rst2_nopend", tripped, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
